// File: rtl/scene_recovery.sv
// Dehaze scene recovery: aligns hazy pixels with their transmission samples through a FIFO,
// then computes J = A + (I - A) / max(t, T0) per channel in a three-stage pipeline.
module scene_recovery #(
  parameter int          FIFO_DEPTH = 2048,
  parameter logic [16:0] T0         = 17'h01999
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [23:0]                   input_pixel,
  input  logic                          input_is_valid,
  input  logic [16:0]                   transmission,
  input  logic                          trans_valid,
  input  logic [23:0]                   atm_light,
  output logic [23:0]                   output_pixel,
  output logic                          output_is_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [15:0] inv_calc(input int k);
    int v;
    if (k == 0) return 16'hFFFF;
    v = ((1 << 20) + k / 2) / k;
    if (v > 65535) return 16'hFFFF;
    return v[15:0];
  endfunction

  // Reciprocal table, fully resolved at elaboration
  logic [15:0] inv_rom [512];
  for (genvar g = 0; g < 512; g++) begin : g_rom
    assign inv_rom[g] = inv_calc(g);
  end

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push_ok, pop_ok;

  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign empty   = (fifo_count == '0);
  assign pop_ok  = trans_valid && !empty;
  assign push_ok = input_is_valid && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= input_pixel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (input_is_valid && full && !pop_ok) fifo_overflow <= 1'b1;
      if (trans_valid && empty)              fifo_underflow <= 1'b1;
    end
  end

  // Stage 1: pop, clamp t, reciprocal lookup
  logic [8:0] k;
  always_comb begin
    k = transmission[16:8];
    if (transmission < T0)               k = T0[16:8];
    else if (transmission > 17'h10000)   k = 9'd256;
  end

  logic        s1_valid;
  logic [23:0] s1_pix, s1_atm;
  logic [15:0] s1_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_atm   <= '0;
      s1_inv   <= '0;
    end else begin
      s1_valid <= pop_ok;
      if (pop_ok) begin
        s1_pix <= mem[rd_ptr];
        s1_atm <= atm_light;
        s1_inv <= inv_rom[k];
      end
    end
  end

  // Stage 2: signed difference times Q4.12 reciprocal
  logic signed [8:0]  d   [3];
  logic signed [25:0] p   [3];
  logic signed [25:0] s2_p [3];
  logic               s2_valid;
  logic [23:0]        s2_atm;

  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      d[c] = $signed({1'b0, s1_pix[8*c +: 8]}) - $signed({1'b0, s1_atm[8*c +: 8]});
      p[c] = d[c] * $signed({1'b0, s1_inv});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_atm   <= '0;
      for (int unsigned c = 0; c < 3; c++) s2_p[c] <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_atm <= s1_atm;
        for (int unsigned c = 0; c < 3; c++) s2_p[c] <= p[c];
      end
    end
  end

  // Stage 3: round, add A, saturate to 0..255
  logic signed [25:0] q [3];
  logic signed [25:0] j [3];
  logic [23:0]        sat_pix;

  always_comb begin
    sat_pix = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      q[c] = (s2_p[c] + 26'sd2048) >>> 12;
      j[c] = q[c] + $signed({18'b0, s2_atm[8*c +: 8]});
      if (j[c][25])              sat_pix[8*c +: 8] = 8'h00;
      else if (j[c] > 26'sd255)  sat_pix[8*c +: 8] = 8'hFF;
      else                       sat_pix[8*c +: 8] = j[c][7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_is_valid <= 1'b0;
      output_pixel    <= '0;
    end else begin
      output_is_valid <= s2_valid;
      if (s2_valid) output_pixel <= sat_pix;
    end
  end

endmodule

// File: tb/tb_scene_recovery.sv
// Directed + randomized bench for scene_recovery; a model FIFO feeds a scoreboard of
// expected pixels tagged with the cycle they must appear in.
module tb_scene_recovery;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic [16:0] transmission;
  logic        trans_valid;
  logic [23:0] atm_light;
  logic [23:0] output_pixel;
  logic        output_is_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        fifo_overflow;
  logic        fifo_underflow;

  scene_recovery #(.FIFO_DEPTH(DEPTH), .T0(17'h01999)) dut (
    .clk(clk), .rst(rst),
    .input_pixel(input_pixel), .input_is_valid(input_is_valid),
    .transmission(transmission), .trans_valid(trans_valid),
    .atm_light(atm_light),
    .output_pixel(output_pixel), .output_is_valid(output_is_valid),
    .fifo_count(fifo_count), .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct { logic [23:0] px; int due; } exp_t;
  exp_t        sb [$];
  logic [23:0] mq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [23:0] i, input logic [23:0] a,
                                        input logic [16:0] t);
    int tc, kk, inv, d, x, q, jj;
    logic [23:0] r;
    r  = '0;
    tc = int'(t);
    if (tc < 'h1999) tc = 'h1999;
    else if (tc > 'h10000) tc = 'h10000;
    kk  = tc / 256;
    inv = (1048576 + kk / 2) / kk;
    for (int c = 0; c < 3; c++) begin
      d  = int'(i[8*c +: 8]) - int'(a[8*c +: 8]);
      x  = d * inv + 2048;
      q  = x >>> 12;
      jj = int'(a[8*c +: 8]) + q;
      if (jj < 0)   jj = 0;
      if (jj > 255) jj = 255;
      r[8*c +: 8] = jj[7:0];
    end
    return r;
  endfunction

  // One cycle of stimulus; exp_px >= 0 overrides the model with a hand-derived value
  task automatic drive(input bit iv, input logic [23:0] ip, input bit tv,
                       input logic [16:0] tr, input int exp_px = -1);
    exp_t        e;
    logic [23:0] pix;
    input_is_valid = iv;
    input_pixel    = ip;
    trans_valid    = tv;
    transmission   = tr;
    if (tv && mq.size() > 0) begin
      pix   = mq.pop_front();
      e.px  = (exp_px < 0) ? model(pix, atm_light, tr) : exp_px[23:0];
      e.due = cyc + 3;
      sb.push_back(e);
    end
    if (iv && mq.size() < DEPTH) mq.push_back(ip);
    @(posedge clk);
    #1;
    input_is_valid = 1'b0;
    trans_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_output", {31'b0, output_is_valid}, 32'd1);
        void'(sb.pop_front());
      end
      if (output_is_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", {31'b0, output_is_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("out_pixel", {8'b0, output_pixel}, {8'b0, e.px});
          chk("out_latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    logic [23:0] px;
    rst = 1'b1;
    input_pixel = '0; input_is_valid = 1'b0;
    transmission = '0; trans_valid = 1'b0; atm_light = '0;
    idle(2);
    chk("rst_count", {27'b0, fifo_count}, 32'd0);
    chk("rst_ovf", {31'b0, fifo_overflow}, 32'd0);
    chk("rst_unf", {31'b0, fifo_underflow}, 32'd0);
    chk("rst_valid", {31'b0, output_is_valid}, 32'd0);
    chk("rst_pixel", {8'b0, output_pixel}, 32'd0);
    rst = 1'b0;

    // Identity, half transmission, clamp/saturation (first push on first edge after reset)
    atm_light = 24'hFFFFFF;
    drive(1, 24'h406080, 0, '0);
    drive(0, '0, 1, 17'h10000, 'h406080);
    idle(4);
    atm_light = 24'hC8C8C8;
    drive(1, 24'h969696, 0, '0);
    drive(0, '0, 1, 17'h08000, 'h646464);
    idle(4);
    drive(1, 24'hD2D2D2, 0, '0);
    drive(1, 24'h000000, 1, 17'h00100, 'hFFFFFF);
    drive(1, 24'h123456, 1, 17'h00100, 'h000000);
    drive(0, '0, 1, 17'h1FFFF);
    idle(4);
    chk("flags_clean_ovf", {31'b0, fifo_overflow}, 32'd0);
    chk("flags_clean_unf", {31'b0, fifo_underflow}, 32'd0);
    chk("count_empty", {27'b0, fifo_count}, 32'd0);

    // Underflow, then pop on empty with a same-cycle push
    drive(0, '0, 1, 17'h10000);
    chk("underflow_set", {31'b0, fifo_underflow}, 32'd1);
    drive(1, 24'hABCDEF, 1, 17'h10000);
    chk("underflow_push_kept", {27'b0, fifo_count}, 32'd1);
    drive(0, '0, 1, 17'h0C000);
    idle(4);

    // Overflow: DEPTH+1 pushes, then full push+pop, then drain in order
    atm_light = 24'h80A0C0;
    for (int i = 0; i <= DEPTH; i++) drive(1, 24'($urandom), 0, '0);
    chk("overflow_set", {31'b0, fifo_overflow}, 32'd1);
    chk("overflow_count", {27'b0, fifo_count}, DEPTH);
    drive(1, 24'($urandom), 1, 17'($urandom_range(0, 'h1FFFF)));
    chk("full_pushpop_count", {27'b0, fifo_count}, DEPTH);
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 17'($urandom_range(0, 'h1FFFF)));
    idle(4);
    chk("drained_count", {27'b0, fifo_count}, 32'd0);
    chk("overflow_sticky", {31'b0, fifo_overflow}, 32'd1);

    // Random mixed traffic
    atm_light = 24'($urandom);
    for (int i = 0; i < 60; i++)
      drive(($urandom % 4) != 0, 24'($urandom), ($urandom % 3) != 0,
            17'($urandom_range(0, 'h1FFFF)));
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++)
      drive(0, '0, 1, 17'($urandom_range(0, 'h1FFFF)));
    idle(4);
    chk("random_count", {27'b0, fifo_count}, 32'd0);

    // Reset mid-stream with 10 queued and 2 in flight
    for (int i = 0; i < 12; i++) drive(1, 24'($urandom), 0, '0);
    drive(0, '0, 1, 17'h10000);
    drive(0, '0, 1, 17'h10000);
    chk("pre_reset_count", {27'b0, fifo_count}, 32'd10);
    rst = 1'b1;
    mq.delete();
    sb.delete();
    #2;
    chk("midrst_count", {27'b0, fifo_count}, 32'd0);
    chk("midrst_valid", {31'b0, output_is_valid}, 32'd0);
    chk("midrst_ovf", {31'b0, fifo_overflow}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(5);
    chk("post_rst_valid", {31'b0, output_is_valid}, 32'd0);
    atm_light = 24'h102030;
    px = 24'h708090;
    drive(1, px, 0, '0);
    drive(0, '0, 1, 17'h06000);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/scene_recovery.md
SCENE_RECOVERY -- requirements
Module: scene_recovery

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2048, pixel alignment FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter T0, default 17'h01999, minimum transmission (0.1 in Q1.16).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port input_pixel  input  24  hazy pixel {R[23:16],G[15:8],B[7:0]}, same stream fed to trans_top.
REQ-006 SHALL have port input_is_valid  input  1  input_pixel valid this cycle.
REQ-007 SHALL have port transmission  input  17  unsigned Q1.16 transmission from trans_top (0x10000 = 1.0).
REQ-008 SHALL have port trans_valid  input  1  transmission valid this cycle.
REQ-009 SHALL have port atm_light  input  24  atmospheric light A per channel, same packing, static during a frame.
REQ-010 SHALL have port output_pixel  output  24  recovered pixel, same packing.
REQ-011 SHALL have port output_is_valid  output  1  output_pixel valid this cycle.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port fifo_overflow  output  1  sticky, push attempted while full.
REQ-014 SHALL have port fifo_underflow  output  1  sticky, trans_valid while FIFO empty.

Function
REQ-015 SHALL push input_pixel into a FIFO on every cycle with input_is_valid=1, in arrival order.
REQ-016 SHALL pop one pixel on every cycle with trans_valid=1 and pair it with that cycle's transmission.
REQ-017 SHALL on push while full (count=FIFO_DEPTH, no pop same cycle): drop the pixel, set fifo_overflow, hold count.
REQ-018 SHALL on full with simultaneous push and pop: accept both, count unchanged.
REQ-019 SHALL on trans_valid while count=0 (before this cycle's push): set fifo_underflow, emit no output for that sample; a same-cycle push is still accepted.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-021 SHALL clamp t: tc = T0 if transmission<T0; tc = 0x10000 if transmission>0x10000; else transmission.
REQ-022 SHALL form index k = tc[16:8] (range 25..256 at default T0) and look up inv = round(2^20/k), unsigned 16-bit Q4.12 (k=256 -> 4096, k=128 -> 8192, k=25 -> 41943).
REQ-023 SHALL per channel compute d = I - A (signed 9-bit), p = d*inv (signed 26-bit), q = (p + 2048) >>> 12 (arithmetic).
REQ-024 SHALL compute J = A + q per channel, saturated to 0..255.
REQ-025 SHALL pipeline in 3 stages (pop/clamp/LUT; multiply; add/saturate): output_is_valid exactly 3 cycles after an accepted trans_valid, full throughput of one pixel per cycle.
REQ-026 SHALL hold output_pixel at its last value when output_is_valid=0.
REQ-027 SHALL sample atm_light in stage 1 together with the popped pixel.
REQ-028 SHALL keep overflow/underflow flags set until reset.

Reset
REQ-029 SHALL on rst=1 asynchronously clear: FIFO pointers, fifo_count=0, fifo_overflow=0, fifo_underflow=0, all pipeline valid bits, output_is_valid=0, output_pixel=24'h000000.
REQ-030 SHALL on reset mid-stream discard all FIFO contents and in-flight pipeline samples; no output_is_valid until a new pop after rst deasserts.
REQ-031 SHALL accept pushes on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL test identity: A=0xFFFFFF, push 0x406080, then transmission=0x10000 -> output_pixel=0x406080 three cycles later.
REQ-033 SHALL test half transmission: A=0xC8C8C8, I=0x969696, transmission=0x8000 -> output_pixel=0x646464.
REQ-034 SHALL test clamp and saturation: A=0xC8C8C8, I=0xD2D2D2, transmission=0x00100 -> k=25, q=102, output_pixel=0xFFFFFF; I=0x000000 -> 0x000000.
REQ-035 SHALL test overflow: FIFO_DEPTH+1 pushes, no trans_valid -> fifo_overflow=1, fifo_count=FIFO_DEPTH, later pops return the first FIFO_DEPTH pixels in order.
REQ-036 SHALL test underflow: trans_valid with empty FIFO -> fifo_underflow=1, no output_is_valid 3 cycles later.
REQ-037 SHALL test reset mid-stream: rst pulsed with 10 pixels queued and 2 in flight -> fifo_count=0, no output_is_valid after reset until the next pop.
